// File: rtl/pc_fetch_if.sv
// Bundle between the decoder/register file and the PC fetch stage.
// The master modport is the fetch unit's view of the bundle.
interface pc_fetch_if #(
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned CNT_W   = 32
);
  logic [31:0]        instr;
  logic               beq;
  logic               bne;
  logic               blez;
  logic               bgtz;
  logic               bz;
  logic               jmp;
  logic               jr;
  logic               jal;
  logic               syscall;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;
  logic [31:0]        v0_data;
  logic               go;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [IMEM_AW-1:0] imem_addr;
  logic               halted;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   jmp_cnt;
  logic [CNT_W-1:0]   br_cnt;

  modport master (
    input  instr, beq, bne, blez, bgtz, bz, jmp, jr, jal, syscall,
    input  rs_data, rt_data, v0_data, go,
    output pc, pc_plus4, imem_addr, halted, cycle_cnt, jmp_cnt, br_cnt
  );

  modport slave (
    output instr, beq, bne, blez, bgtz, bz, jmp, jr, jal, syscall,
    output rs_data, rt_data, v0_data, go,
    input  pc, pc_plus4, imem_addr, halted, cycle_cnt, jmp_cnt, br_cnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC stage of the single-cycle MIPS core: next-PC selection, RUN/HALT control on
// SYSCALL exit, GO-edge resume and run statistics counters.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input logic        clk,
  input logic        rst_n,
  pc_fetch_if.master bus
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q;
  logic             halted_q;
  logic             go_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] jmp_q;
  logic [CNT_W-1:0] br_q;

  logic        [31:0] pc_plus4;
  logic        [31:0] br_tgt;
  logic        [31:0] j_tgt;
  logic        [31:0] run_next_pc;
  logic signed [31:0] rs_s;
  logic               br_take;
  logic               halt_req;
  logic               go_rise;
  logic               any_jump;

  // Opcode field and JAL strobe carry no information this stage needs; JAL
  // always arrives together with the generic jump strobe.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[31:26], bus.jal};

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
  assign rs_s     = $signed(bus.rs_data);
  assign halt_req = bus.syscall & (bus.v0_data == 32'd10);
  assign go_rise  = bus.go & ~go_q;
  assign any_jump = bus.jmp | bus.jr;

  always_comb begin
    br_take = (bus.beq  & (bus.rs_data == bus.rt_data))
            | (bus.bne  & (bus.rs_data != bus.rt_data))
            | (bus.blez & (rs_s <= 32'sd0))
            | (bus.bgtz & (rs_s >  32'sd0))
            | (bus.bz   & ~bus.instr[16] & (rs_s <  32'sd0))
            | (bus.bz   &  bus.instr[16] & (rs_s >= 32'sd0));
  end

  // JR wins over the generic jump strobe the decoder raises alongside it.
  always_comb begin
    run_next_pc = pc_plus4;
    if (bus.jr) begin
      run_next_pc = bus.rs_data;
    end else if (bus.jmp) begin
      run_next_pc = j_tgt;
    end else if (br_take) begin
      run_next_pc = br_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
      go_q     <= 1'b0;
      pc_q     <= RESET_PC;
      cycle_q  <= '0;
      jmp_q    <= '0;
      br_q     <= '0;
    end else begin
      go_q <= bus.go;
      unique case (state_q)
        StRun: begin
          cycle_q <= cycle_q + CNT_W'(1);
          if (halt_req) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            pc_q <= run_next_pc;
            if (any_jump) begin
              jmp_q <= jmp_q + CNT_W'(1);
            end else if (br_take) begin
              br_q <= br_q + CNT_W'(1);
            end
          end
        end
        StHalt: begin
          if (go_rise) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            pc_q     <= pc_plus4;
          end
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.imem_addr = pc_q[IMEM_AW+1:2];
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.jmp_cnt   = jmp_q;
  assign bus.br_cnt    = br_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a 32-bit-counter and a 4-bit-counter instance share
// stimulus; a behavioural model is compared every cycle, plus literal spot checks.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] instr, rs, rt, v0;
  logic beq, bne, blez, bgtz, bz, jmp, jr, jal, syscall, go;

  pc_fetch_if #(.IMEM_AW(10), .CNT_W(32)) bus ();
  pc_fetch_if #(.IMEM_AW(10), .CNT_W(4))  bus4 ();

  assign bus.instr = instr;     assign bus4.instr = instr;
  assign bus.beq = beq;         assign bus4.beq = beq;
  assign bus.bne = bne;         assign bus4.bne = bne;
  assign bus.blez = blez;       assign bus4.blez = blez;
  assign bus.bgtz = bgtz;       assign bus4.bgtz = bgtz;
  assign bus.bz = bz;           assign bus4.bz = bz;
  assign bus.jmp = jmp;         assign bus4.jmp = jmp;
  assign bus.jr = jr;           assign bus4.jr = jr;
  assign bus.jal = jal;         assign bus4.jal = jal;
  assign bus.syscall = syscall; assign bus4.syscall = syscall;
  assign bus.rs_data = rs;      assign bus4.rs_data = rs;
  assign bus.rt_data = rt;      assign bus4.rt_data = rt;
  assign bus.v0_data = v0;      assign bus4.v0_data = v0;
  assign bus.go = go;           assign bus4.go = go;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_AW(10), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_AW(10), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state advanced once per rising edge.
  logic [31:0] m_pc, m_cyc, m_jmp, m_br;
  bit m_halt, m_go_prev, m_valid = 0;

  function automatic bit model_branch();
    int s;
    s = $signed(rs);
    if (beq && rs == rt) return 1;
    if (bne && rs != rt) return 1;
    if (blez && s <= 0) return 1;
    if (bgtz && s > 0) return 1;
    if (bz) return instr[16] ? (s >= 0) : (s < 0);
    return 0;
  endfunction

  task automatic model_step();
    int off;
    if (!rst_n) begin
      m_pc = 32'h3000; m_halt = 0; m_cyc = 0; m_jmp = 0; m_br = 0; m_go_prev = 0;
      m_valid = 1;
      return;
    end
    if (m_halt) begin
      if (go && !m_go_prev) begin
        m_halt = 0;
        m_pc = m_pc + 4;
      end
    end else begin
      m_cyc = m_cyc + 1;
      if (syscall && v0 == 10) begin
        m_halt = 1;
      end else if (jr) begin
        m_pc = rs; m_jmp = m_jmp + 1;
      end else if (jmp) begin
        m_pc = ((m_pc + 4) & 32'hF000_0000) | (32'(instr[25:0]) * 4); m_jmp = m_jmp + 1;
      end else if (model_branch()) begin
        off = $signed(instr[15:0]);
        m_pc = m_pc + 4 + 32'(off * 4); m_br = m_br + 1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    m_go_prev = go;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", bus.pc, m_pc);
      chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      chk("imem_addr", 32'(bus.imem_addr), (m_pc >> 2) & 32'h3FF);
      chk("halted", 32'(bus.halted), 32'(m_halt));
      chk("cycle_cnt", bus.cycle_cnt, m_cyc);
      chk("jmp_cnt", bus.jmp_cnt, m_jmp);
      chk("br_cnt", bus.br_cnt, m_br);
      chk("pc4", bus4.pc, m_pc);
      chk("cycle_cnt4", 32'(bus4.cycle_cnt), m_cyc & 32'hF);
      chk("jmp_cnt4", 32'(bus4.jmp_cnt), m_jmp & 32'hF);
      chk("br_cnt4", 32'(bus4.br_cnt), m_br & 32'hF);
    end
  end

  task automatic idle();
    instr = 32'h0000_0020;
    {beq, bne, blez, bgtz, bz, jmp, jr, jal, syscall} = '0;
    rs = 0; rt = 0; v0 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // BLTZ, BGEZ, BLEZ, BGTZ for rs = 0x8000_0000 then rs = 0
  logic [31:0] br_rs [8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    rst_n = 1'b0; go = 1'b0; idle();
    tick(); tick();
    chk("reset_pc", bus.pc, 32'h3000);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_cycle", bus.cycle_cnt, 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("alu_pc", bus.pc, 32'h3000 + 32'(4 * i));
    end
    chk("alu_cycle", bus.cycle_cnt, 32'd4);
    chk("alu_jmp_br", bus.jmp_cnt | bus.br_cnt, 32'd0);

    beq = 1; instr = {6'h04, 5'd1, 5'd2, 16'hFFFF}; rs = 5; rt = 5;
    tick();
    chk("beq_taken_pc", bus.pc, 32'h3010);
    chk("beq_taken_br", bus.br_cnt, 32'd1);
    rt = 6;
    tick();
    chk("beq_not_pc", bus.pc, 32'h3014);
    idle();

    jmp = 1; instr = {6'h02, 26'h0000C40};
    tick();
    chk("j_pc", bus.pc, 32'h3100);
    jmp = 1; jr = 1; rs = 32'h3020; instr = 32'h03E0_0008;
    tick();
    chk("jr_pc", bus.pc, 32'h3020);
    chk("jr_jmp", bus.jmp_cnt, 32'd2);
    idle(); jmp = 1; jal = 1; instr = {6'h03, 26'h0000C09};
    tick();
    chk("jal_pc", bus.pc, 32'h3024);
    idle();

    for (int i = 0; i < 8; i++) begin
      idle();
      rs = br_rs[i];
      instr = {6'h01, 5'd3, 5'd0, 16'h0004};
      case (i % 4)
        0: bz = 1;
        1: begin bz = 1; instr[16] = 1'b1; end
        2: blez = 1;
        default: bgtz = 1;
      endcase
      tick();
    end
    chk("cond_br_cnt", bus.br_cnt, 32'd5);
    idle(); jmp = 1; jr = 1; rs = 32'h3040;
    tick();
    chk("jr2_pc", bus.pc, 32'h3040);

    idle(); syscall = 1; v0 = 10;
    tick();
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_pc", bus.pc, 32'h3040);
    chk("halt_cycle", bus.cycle_cnt, 32'd19);
    for (int i = 0; i < 20; i++) begin
      syscall = 1; v0 = 10; beq = 1; rs = 0; rt = 0;
      jmp = 1'($urandom_range(0, 1)); jr = 1'($urandom_range(0, 1));
      tick();
    end
    chk("frozen_pc", bus.pc, 32'h3040);
    chk("frozen_cycle", bus.cycle_cnt, 32'd19);
    chk("frozen_jmp", bus.jmp_cnt, 32'd4);
    idle(); go = 1;
    tick();
    chk("resume_pc", bus.pc, 32'h3044);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    syscall = 1; v0 = 1;
    tick();
    chk("sys_noop_pc", bus.pc, 32'h3048);
    v0 = 10;
    tick();
    idle();
    tick(); tick(); tick();
    chk("go_held_pc", bus.pc, 32'h3048);
    chk("go_held_halted", 32'(bus.halted), 32'd1);
    go = 0; tick();
    go = 1; tick();
    chk("resume2_pc", bus.pc, 32'h304C);

    syscall = 1; v0 = 10;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("rst_halt_pc", bus.pc, 32'h3000);
    chk("rst_halt_flag", 32'(bus.halted), 32'd0);
    chk("rst_halt_cnt", bus.cycle_cnt | bus.jmp_cnt | bus.br_cnt, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("wrap_cycle4", 32'(bus4.cycle_cnt), 32'd1);
    chk("wrap_cycle32", bus.cycle_cnt, 32'd17);
    chk("wrap_pc", bus.pc, 32'h3044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
